// File: rtl/can_reg_write_ctrl.sv
// Host register-write front end for the CAN core register bank: one-hot single-cycle write strobes, bus ack, protection/range error flag.
// Latency: cs seen at edge N -> ack/reg_we high in cycle N+1. Optional `CAN_WR_DROP_CNT_EN adds a saturating drop counter.
module can_reg_write_ctrl #(
  parameter int          DATA_W    = 8,
  parameter int          ADDR_W    = 5,
  parameter int          NUM_REGS  = 32,
  parameter logic [31:0] PROT_MASK = 32'h0000_003F
) (
  input  logic                clk,
  input  logic                rst_sync,
  input  logic                cs,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                reset_mode,
  input  logic                err_clr,
  output logic [DATA_W-1:0]   reg_data,
  output logic [NUM_REGS-1:0] reg_we,
  output logic                ack,
  output logic                wr_err
`ifdef CAN_WR_DROP_CNT_EN
  ,
  output logic [7:0]          drop_cnt
`endif
);

  localparam int                AW_N       = 1 << ADDR_W;
  localparam logic [AW_N-1:0]   PROT_VEC   = AW_N'(PROT_MASK);
  localparam logic [ADDR_W:0]   NUM_REGS_L = (ADDR_W+1)'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, STROBE, HOLD} state_t;

  state_t              state, state_nxt;
  logic                cap_we;
  logic                cap_rm;
  logic [ADDR_W-1:0]   cap_addr;
  logic                armed;
  logic                capture;
  logic                in_range;
  logic                permitted;
  logic                wr_ok;
  logic                drop_evt;

  // A cs held high through reset must be released before it can start a new access.
  assign capture   = (state == IDLE) && cs && armed && !rst_sync;
  assign in_range  = {1'b0, cap_addr} < NUM_REGS_L;
  assign permitted = in_range && (!PROT_VEC[cap_addr] || cap_rm);
  assign wr_ok     = (state == STROBE) && cap_we && permitted && !rst_sync;
  assign drop_evt  = (state == STROBE) && cap_we && !permitted && !rst_sync;

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state    <= IDLE;
      cap_we   <= 1'b0;
      cap_rm   <= 1'b0;
      cap_addr <= '0;
      reg_data <= '0;
      armed    <= ~cs;
      wr_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= armed | ~cs;
      if (capture) begin
        cap_we   <= we;
        cap_rm   <= reset_mode;
        cap_addr <= addr;
        reg_data <= data_in;
      end
      if (drop_evt)
        wr_err <= 1'b1;
      else if (err_clr)
        wr_err <= 1'b0;
    end
  end

`ifdef CAN_WR_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      drop_cnt <= 8'h00;
    end else if (drop_evt) begin
      if (err_clr)
        drop_cnt <= 8'h01;
      else if (drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'h01;
    end else if (err_clr) begin
      drop_cnt <= 8'h00;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    ack       = 1'b0;
    case (state)
      IDLE:    if (capture) state_nxt = STROBE;
      STROBE: begin
        ack       = 1'b1;
        state_nxt = HOLD;
      end
      HOLD:    if (!cs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Reset cancels any strobe in flight, even combinationally within the cycle.
    if (rst_sync) begin
      ack       = 1'b0;
      state_nxt = IDLE;
    end
  end

  always_comb begin
    reg_we = '0;
    for (int i = 0; i < NUM_REGS; i++)
      reg_we[i] = wr_ok && (cap_addr == ADDR_W'(i));
  end

endmodule

// File: tb/tb_can_reg_write_ctrl.sv
// Randomised self-checking bench for can_reg_write_ctrl with a spec-level reference model (NUM_REGS=20).
module tb_can_reg_write_ctrl;
  localparam int          NR = 20;
  localparam logic [31:0] PM = 32'h0000_003F;

  logic          clk = 1'b0;
  logic          rst_sync, cs, we, reset_mode, err_clr;
  logic [4:0]    addr;
  logic [7:0]    data_in, reg_data;
  logic [NR-1:0] reg_we;
  logic          ack, wr_err;
`ifdef CAN_WR_DROP_CNT_EN
  logic [7:0]    drop_cnt;
`endif

  int   errors = 0;
  int   checks = 0;
  logic exp_err = 1'b0;
  int   exp_drop = 0;

  can_reg_write_ctrl #(.DATA_W(8), .ADDR_W(5), .NUM_REGS(NR), .PROT_MASK(PM)) dut (
    .clk(clk), .rst_sync(rst_sync), .cs(cs), .we(we), .addr(addr), .data_in(data_in),
    .reset_mode(reset_mode), .err_clr(err_clr), .reg_data(reg_data), .reg_we(reg_we),
    .ack(ack), .wr_err(wr_err)
`ifdef CAN_WR_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic allowed(input logic [4:0] a, input logic rm);
    return (int'(a) < NR) && (!PM[a] || rm);
  endfunction

  function automatic logic [NR-1:0] onehot(input logic [4:0] a);
    logic [NR-1:0] v;
    v = '0;
    if (int'(a) < NR) v[a] = 1'b1;
    return v;
  endfunction

  task automatic note_drop(input logic dropped, input logic clr);
    if (dropped) begin
      exp_err  = 1'b1;
      exp_drop = clr ? 1 : (exp_drop < 255 ? exp_drop + 1 : 255);
    end else if (clr) begin
      exp_err  = 1'b0;
      exp_drop = 0;
    end
  endtask

  // Drives one bus cycle with cs high for 'hold' sampling edges and records what the bus saw.
  task automatic do_access(input logic w, input logic [4:0] a, input logic [7:0] d, input logic rm,
                           input int hold, output logic a1, output logic [NR-1:0] w1,
                           output logic [7:0] d1, output int nack, output int nwe);
    nack = 0; nwe = 0;
    cs = 1'b1; we = w; addr = a; data_in = d; reset_mode = rm;
    @(posedge clk); #1;
    reset_mode = ~rm;
    cs = (1 < hold);
    @(negedge clk);
    a1 = ack; w1 = reg_we; d1 = reg_data;
    nack += int'(ack); nwe += int'(reg_we != '0);
    for (int i = 2; i <= hold + 2; i++) begin
      @(posedge clk); #1;
      cs = (i < hold);
      @(negedge clk);
      nack += int'(ack); nwe += int'(reg_we != '0);
    end
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    note_drop(1'b0, 1'b1);
  endtask

  task automatic test_reset();
    rst_sync = 1'b1; cs = 1'b0; we = 1'b0; addr = '0; data_in = '0; reset_mode = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_sync = 1'b0;
    @(negedge clk);
    exp_err = 1'b0; exp_drop = 0;
    checks++; if (reg_data !== 8'h00) begin errors++; $display("FAIL reset_reg_data got=%h exp=00", reg_data); end
    checks++; if (reg_we !== '0) begin errors++; $display("FAIL reset_reg_we got=%h exp=0", reg_we); end
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", ack); end
    checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL reset_wr_err got=%b exp=0", wr_err); end
`ifdef CAN_WR_DROP_CNT_EN
    checks++; if (drop_cnt !== 8'h00) begin errors++; $display("FAIL reset_drop_cnt got=%h exp=00", drop_cnt); end
`endif
  endtask

  task automatic test_write_enable();
    logic a1; logic [NR-1:0] w1; logic [7:0] d1; int na, nw;
    do_access(1'b1, 5'd5, 8'hA5, 1'b1, 1, a1, w1, d1, na, nw);
    checks++; if (a1 !== 1'b1) begin errors++; $display("FAIL we_ack got=%b exp=1", a1); end
    checks++; if (w1 !== 20'h00020) begin errors++; $display("FAIL we_reg_we got=%h exp=00020", w1); end
    checks++; if (d1 !== 8'hA5) begin errors++; $display("FAIL we_reg_data got=%h exp=a5", d1); end
    checks++; if (na != 1 || nw != 1) begin errors++; $display("FAIL we_pulse_count acks=%0d wes=%0d exp=1/1", na, nw); end
    checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL we_wr_err got=%b exp=0", wr_err); end
  endtask

  task automatic test_protected();
    logic a1; logic [NR-1:0] w1; logic [7:0] d1; int na, nw;
    do_access(1'b1, 5'd3, 8'h12, 1'b0, 1, a1, w1, d1, na, nw);
    note_drop(1'b1, 1'b0);
    checks++; if (a1 !== 1'b1 || w1 !== '0) begin errors++; $display("FAIL prot_strobe ack=%b we=%h exp=1/0", a1, w1); end
    checks++; if (wr_err !== 1'b1) begin errors++; $display("FAIL prot_wr_err got=%b exp=1", wr_err); end
    pulse_clr();
    checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL prot_clr got=%b exp=0", wr_err); end
`ifdef CAN_WR_DROP_CNT_EN
    checks++; if (drop_cnt !== 8'h00) begin errors++; $display("FAIL prot_clr_cnt got=%h exp=00", drop_cnt); end
`endif
  endtask

  task automatic test_out_of_range();
    logic a1; logic [NR-1:0] w1; logic [7:0] d1; int na, nw;
    do_access(1'b1, 5'd25, 8'h3C, 1'b1, 1, a1, w1, d1, na, nw);
    note_drop(1'b1, 1'b0);
    checks++; if (a1 !== 1'b1 || w1 !== '0) begin errors++; $display("FAIL oor_strobe ack=%b we=%h exp=1/0", a1, w1); end
    checks++; if (wr_err !== 1'b1) begin errors++; $display("FAIL oor_wr_err got=%b exp=1", wr_err); end
`ifdef CAN_WR_DROP_CNT_EN
    checks++; if (drop_cnt !== 8'h01) begin errors++; $display("FAIL oor_drop_cnt got=%h exp=01", drop_cnt); end
`endif
    pulse_clr();
  endtask

  task automatic test_read_long_cs();
    logic a1; logic [NR-1:0] w1; logic [7:0] d1; int na, nw;
    do_access(1'b0, 5'd7, 8'h99, 1'b0, 6, a1, w1, d1, na, nw);
    checks++; if (na != 1) begin errors++; $display("FAIL read_ack_count got=%0d exp=1", na); end
    checks++; if (nw != 0) begin errors++; $display("FAIL read_reg_we_cycles got=%0d exp=0", nw); end
    checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL read_wr_err got=%b exp=0", wr_err); end
  endtask

  task automatic test_reset_mid();
    int na;
    cs = 1'b1; we = 1'b1; addr = 5'd10; data_in = 8'h77; reset_mode = 1'b1;
    @(posedge clk); #1;
    rst_sync = 1'b1;
    @(negedge clk);
    checks++; if (ack !== 1'b0 || reg_we !== '0) begin errors++; $display("FAIL rstmid_strobe ack=%b we=%h exp=0/0", ack, reg_we); end
    @(posedge clk); #1;
    rst_sync = 1'b0;
    exp_err = 1'b0; exp_drop = 0;
    @(negedge clk);
    checks++; if (reg_data !== 8'h00) begin errors++; $display("FAIL rstmid_reg_data got=%h exp=00", reg_data); end
    na = 0;
    repeat (4) begin
      @(posedge clk); @(negedge clk);
      na += int'(ack) + int'(reg_we != '0);
    end
    checks++; if (na != 0) begin errors++; $display("FAIL rstmid_no_restrobe got=%0d exp=0", na); end
    #1 cs = 1'b0;
    @(posedge clk); #1;
    cs = 1'b1;
    @(posedge clk); #1;
    cs = 1'b0;
    @(negedge clk);
    checks++; if (ack !== 1'b1 || reg_we !== onehot(5'd10)) begin errors++; $display("FAIL rstmid_new_cs ack=%b we=%h exp=1/%h", ack, reg_we, onehot(5'd10)); end
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_collision();
    cs = 1'b1; we = 1'b1; addr = 5'd2; data_in = 8'h55; reset_mode = 1'b0;
    @(posedge clk); #1;
    cs = 1'b0; err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    note_drop(1'b1, 1'b1);
    @(negedge clk);
    checks++; if (wr_err !== 1'b1) begin errors++; $display("FAIL collide_wr_err got=%b exp=1", wr_err); end
`ifdef CAN_WR_DROP_CNT_EN
    checks++; if (int'(drop_cnt) != exp_drop) begin errors++; $display("FAIL collide_drop_cnt got=%0d exp=%0d", drop_cnt, exp_drop); end
`endif
    @(posedge clk);
    @(negedge clk);
    pulse_clr();
  endtask

  task automatic test_random();
    logic a1; logic [NR-1:0] w1; logic [7:0] d1; int na, nw;
    logic w, rm; logic [4:0] a; logic [7:0] d; logic [NR-1:0] ew;
    for (int n = 0; n < 60; n++) begin
      w  = ($urandom_range(0, 3) != 0);
      a  = 5'($urandom_range(0, 31));
      rm = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      do_access(w, a, d, rm, int'($urandom_range(1, 3)), a1, w1, d1, na, nw);
      ew = (w && allowed(a, rm)) ? onehot(a) : '0;
      note_drop(w && !allowed(a, rm), 1'b0);
      checks++;
      if (a1 !== 1'b1 || w1 !== ew || d1 !== d || na != 1 || nw != int'(ew != '0) || wr_err !== exp_err) begin
        errors++;
        $display("FAIL rand_%0d ack=%b we=%h data=%h acks=%0d err=%b exp ack=1 we=%h data=%h acks=1 err=%b",
                 n, a1, w1, d1, na, wr_err, ew, d, exp_err);
      end
`ifdef CAN_WR_DROP_CNT_EN
      checks++; if (int'(drop_cnt) != exp_drop) begin errors++; $display("FAIL rand_cnt_%0d got=%0d exp=%0d", n, drop_cnt, exp_drop); end
`endif
      if ($urandom_range(0, 4) == 0) pulse_clr();
    end
  endtask

`ifdef CAN_WR_DROP_CNT_EN
  task automatic test_saturation();
    logic a1; logic [NR-1:0] w1; logic [7:0] d1; int na, nw;
    pulse_clr();
    for (int n = 0; n < 300; n++) begin
      do_access(1'b1, 5'd1, 8'($urandom), 1'b0, 1, a1, w1, d1, na, nw);
      note_drop(1'b1, 1'b0);
      if (n == 253) begin
        checks++; if (int'(drop_cnt) != exp_drop) begin errors++; $display("FAIL sat_254 got=%0d exp=%0d", drop_cnt, exp_drop); end
      end
    end
    checks++; if (drop_cnt !== 8'hFF) begin errors++; $display("FAIL sat_300 got=%h exp=ff", drop_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_enable();
    test_protected();
    test_out_of_range();
    test_read_long_cs();
    test_reset_mid();
    test_collision();
    test_random();
`ifdef CAN_WR_DROP_CNT_EN
    test_saturation();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
